dllp_rx_handler_mvc: RTL and testbench
======================================

Name: dllp_rx_handler_mvc

Overview:
Receive-side DLLP decoder for the datalink layer, generalised to NUM_VC virtual channels and 32- or 64-bit PHY datapaths. Accepts DLLP beats from the PHY AXIS stream and checks CRC16. Decodes Ack/Nak into sequence-number reports to the replay logic and maintains per-VC transmit flow-control credits and InitFC1/InitFC2 completion status. Also keeps saturating error counters and discards stale Acks/Naks.

Parameters:
DATA_WIDTH, 32, PHY stream width; only 32 (two beats per DLLP) or 64 (one beat per DLLP) are legal.
KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
USER_WIDTH, 4, tuser width; bit 0 marks a DLLP beat.
NUM_VC, 1, number of supported VCs (1..8).
ERR_CNT_WIDTH, 16, width of the error counters.

Ports:
clk_i  in  1  clock; the block has one clock domain.
rst_ni  in  1  asynchronous reset, active low.
phy_link_up_i  in  1  PHY link status.
s_axis_tdata  in  DATA_WIDTH  DLLP bytes; byte0 is in tdata[7:0].
s_axis_tkeep  in  KEEP_WIDTH  byte enables; not checked.
s_axis_tvalid  in  1  beat valid.
s_axis_tlast  in  1  last beat of a packet.
s_axis_tuser  in  USER_WIDTH  bit 0 set = DLLP beat.
s_axis_tready  out  1  beat accepted.
seq_num_o  out  12  acknowledged or nak'd sequence number.
seq_num_vld_o  out  1  one-cycle pulse.
seq_num_acknack_o  out  1  1 = Ack, 0 = Nak; qualified by seq_num_vld_o.
tx_fc_ph_o / tx_fc_nph_o / tx_fc_cplh_o  out  8*NUM_VC  header credits, VC n in bits [8n+7:8n].
tx_fc_pd_o / tx_fc_npd_o / tx_fc_cpld_o  out  12*NUM_VC  data credits, VC n in bits [12n+11:12n].
update_fc_o  out  NUM_VC  one-cycle pulse per VC when that VC's credits change.
fc1_values_stored_o  out  NUM_VC  InitFC1 P, NP and Cpl all received for the VC.
fc2_values_stored_o  out  NUM_VC  InitFC2 P, NP and Cpl all received for the VC.
crc_err_cnt_o  out  ERR_CNT_WIDTH  count of DLLPs dropped for bad CRC.
malformed_cnt_o  out  ERR_CNT_WIDTH  count of short or overlong DLLPs and DLLPs with unsupported VC or type.

Behaviour:
- Reset: every output register is 0, FSM is in ST_IDLE and s_axis_tready is 0.
- Input path: s_axis is registered through the existing axis_register skid buffer; the FSM handshakes on the buffer's output side.
- Link down (phy_link_up_i=0): the FSM returns to ST_IDLE next cycle and any partial DLLP is dropped. FC values and both stored masks clear. Error counters keep their values. tready is held 0 until link up.
- Beats with tuser[0]=0 arriving in ST_IDLE are accepted and discarded; they have no effect on state.
- DLLP layout: body is bytes 0-3 and CRC is bytes 4-5.
  - DATA_WIDTH=32: body on beat 1, CRC on tdata[15:0] of beat 2.
  - DATA_WIDTH=64: body on tdata[31:0], CRC on tdata[47:32].
- CRC check: expected value is ~crc_out, where pcie_datalink_crc is fed the body with crcIn all ones.
- FSM states:
  - ST_IDLE: tready=1. A DLLP beat latches the body. DATA_WIDTH=32 goes to ST_CRC; DATA_WIDTH=64 checks CRC on the same beat and goes to ST_PROCESS or, on mismatch, back to ST_IDLE.
  - ST_IDLE, DATA_WIDTH=32, tlast already set on the first beat: count malformed and stay in ST_IDLE.
  - ST_CRC: tready=1. On the CRC beat: match goes to ST_PROCESS; mismatch increments crc_err_cnt and goes to ST_IDLE. If that beat has tlast=0, count malformed and enter ST_FLUSH.
  - ST_FLUSH: tready=1; discard beats until tlast, then go to ST_IDLE.
  - ST_PROCESS: tready=0; decode for one cycle, then go to ST_IDLE. Throughput is at most one DLLP per 3 cycles at 32-bit and per 2 cycles at 64-bit.
- Decode in ST_PROCESS (type = byte0):
  - Ack 0x00 / Nak 0x10: seq = {byte2[3:0], byte3}.
    - Stale test: ((seq - last_seq) mod 4096) >= 2048, after the first Ack/Nak since link up.
    - Stale: discard with no pulse.
    - Otherwise: pulse seq_num_vld_o with seq_num_acknack_o per type and update last_seq.
  - FC types: high nibble 0x4/0x5/0x6 = InitFC1 P/NP/Cpl, 0xC/0xD/0xE = InitFC2 P/NP/Cpl, 0x8/0x9/0xA = UpdateFC P/NP/Cpl; VC = byte0[2:0].
    - Field extraction: HdrFC = {byte1[5:0], byte2[7:6]}, DataFC = {byte2[3:0], byte3}.
    - VC >= NUM_VC: count malformed and ignore.
    - InitFC1/InitFC2: write the credits and set the corresponding stored bit.
    - Completion pulse: when fc2_values_stored_o[vc] becomes 1, update_fc_o[vc] pulses.
    - UpdateFC: accepted only when fc2_values_stored_o[vc]=1; it writes the credits and pulses update_fc_o[vc]. Otherwise it is ignored with no counter change.
  - PM 0x20-0x24 and Vendor 0x30: accepted with no effect.
  - Any other type: count malformed.
- Output timing: seq_num_*, update_fc_o and the credit outputs all change in the cycle after ST_PROCESS.
- Counters saturate at all ones; there is no wrap.

Test Plan:
- 32-bit, NUM_VC=2: InitFC1 P/NP/Cpl then InitFC2 P/NP/Cpl on VC1, P with HdrFC=0x20 and DataFC=0x100 -> fc2_values_stored_o=2'b10, tx_fc_ph_o[15:8]=0x20, tx_fc_pd_o[23:12]=0x100, update_fc_o=2'b10 pulses once.
- UpdateFC_P on VC0 before VC0 InitFC2 completes -> no credit change and no pulse; after InitFC2 completes, the same DLLP updates credits and pulses update_fc_o[0].
- Ack 5, then Nak 7, then Ack 4094 -> first two pulse seq_num_vld_o with acknack 1 then 0 and seq 5 then 7; Ack 4094 is stale and discarded. Repeat wrap check: last_seq=4090, Ack 3 -> forwarded.
- Bad CRC on Ack 9 -> no pulse, crc_err_cnt_o=1; the next good DLLP is decoded normally.
- InitFC1 on VC5 with NUM_VC=2 -> malformed_cnt_o increments; single-beat DLLP at 32-bit -> malformed_cnt_o increments.
- phy_link_up_i dropped between beat 1 and beat 2 -> DLLP dropped, credits and stored masks cleared, crc_err_cnt_o unchanged; rst_ni asserted mid-packet -> all outputs 0 immediately.

Source files
------------

// File: rtl/dllp_rx_handler_mvc.sv
// Receive-side DLLP decoder: skid-buffered PHY stream, CRC16 check, Ack/Nak reporting,
// per-VC flow-control credit tracking and saturating error counters.
module dllp_rx_handler_mvc #(
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int USER_WIDTH    = 4,
  parameter int NUM_VC        = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     phy_link_up_i,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser,
  output logic                     s_axis_tready,
  output logic [11:0]              seq_num_o,
  output logic                     seq_num_vld_o,
  output logic                     seq_num_acknack_o,
  output logic [8*NUM_VC-1:0]      tx_fc_ph_o,
  output logic [12*NUM_VC-1:0]     tx_fc_pd_o,
  output logic [8*NUM_VC-1:0]      tx_fc_nph_o,
  output logic [12*NUM_VC-1:0]     tx_fc_npd_o,
  output logic [8*NUM_VC-1:0]      tx_fc_cplh_o,
  output logic [12*NUM_VC-1:0]     tx_fc_cpld_o,
  output logic [NUM_VC-1:0]        update_fc_o,
  output logic [NUM_VC-1:0]        fc1_values_stored_o,
  output logic [NUM_VC-1:0]        fc2_values_stored_o,
  output logic [ERR_CNT_WIDTH-1:0] crc_err_cnt_o,
  output logic [ERR_CNT_WIDTH-1:0] malformed_cnt_o
);

  localparam bit WIDE = (DATA_WIDTH == 64);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CRC     = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_PROCESS = 2'd3;

  // CRC16 (poly 0x100B), bytes in order, each byte LSB first
  function automatic logic [15:0] pcie_datalink_crc(input logic [31:0] data, input logic [15:0] crc_in);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h100B;
    end
    return c;
  endfunction

  // ---------------- input skid buffer ----------------
  logic [DATA_WIDTH-1:0] out_data_reg, tmp_data_reg;
  logic                  out_valid_reg, out_last_reg, out_user_reg;
  logic                  tmp_valid_reg, tmp_last_reg, tmp_user_reg;
  logic                  in_ready_reg;
  logic                  in_ready_early;
  logic                  out_valid_next, tmp_valid_next;
  logic                  in_to_out, in_to_tmp, tmp_to_out;
  logic                  out_ready;
  logic                  fire;

  assign s_axis_tready = in_ready_reg;

  always_comb begin
    in_ready_early = out_ready || (!tmp_valid_reg && (!out_valid_reg || !s_axis_tvalid));
    out_valid_next = out_valid_reg;
    tmp_valid_next = tmp_valid_reg;
    in_to_out      = 1'b0;
    in_to_tmp      = 1'b0;
    tmp_to_out     = 1'b0;
    if (in_ready_reg) begin
      if (out_ready || !out_valid_reg) begin
        out_valid_next = s_axis_tvalid;
        in_to_out      = 1'b1;
      end else begin
        tmp_valid_next = s_axis_tvalid;
        in_to_tmp      = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_next = tmp_valid_reg;
      tmp_valid_next = 1'b0;
      tmp_to_out     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      tmp_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_user_reg  <= 1'b0;
      tmp_data_reg  <= '0;
      tmp_last_reg  <= 1'b0;
      tmp_user_reg  <= 1'b0;
    end else begin
      in_ready_reg  <= in_ready_early && phy_link_up_i;
      out_valid_reg <= out_valid_next && phy_link_up_i;
      tmp_valid_reg <= tmp_valid_next && phy_link_up_i;
      if (in_to_out) begin
        out_data_reg <= s_axis_tdata;
        out_last_reg <= s_axis_tlast;
        out_user_reg <= s_axis_tuser[0];
      end else if (tmp_to_out) begin
        out_data_reg <= tmp_data_reg;
        out_last_reg <= tmp_last_reg;
        out_user_reg <= tmp_user_reg;
      end
      if (in_to_tmp) begin
        tmp_data_reg <= s_axis_tdata;
        tmp_last_reg <= s_axis_tlast;
        tmp_user_reg <= s_axis_tuser[0];
      end
    end
  end

  // ---------------- beat field extraction ----------------
  logic [31:0] beat_body;
  logic [15:0] crc_field;

  if (WIDE) begin : g_w64
    logic unused_hi;
    assign beat_body = out_data_reg[31:0];
    assign crc_field = out_data_reg[47:32];
    assign unused_hi = ^out_data_reg[DATA_WIDTH-1:48];
  end else begin : g_w32
    assign beat_body = out_data_reg[31:0];
    assign crc_field = out_data_reg[15:0];
  end

  // ---------------- FSM ----------------
  logic [1:0]  state_reg, state_next;
  logic [31:0] body_reg;
  logic [31:0] crc_body;
  logic        crc_ok;
  logic        body_load;
  logic        crc_err_inc;
  logic        fsm_malformed;

  assign out_ready = phy_link_up_i && (state_reg != ST_PROCESS);
  assign fire      = out_valid_reg && out_ready;
  assign crc_body  = (state_reg == ST_IDLE) ? beat_body : body_reg;
  assign crc_ok    = (crc_field == ~pcie_datalink_crc(crc_body, 16'hFFFF));

  always_comb begin
    state_next    = state_reg;
    body_load     = 1'b0;
    crc_err_inc   = 1'b0;
    fsm_malformed = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (fire && out_user_reg) begin
          body_load = 1'b1;
          if (WIDE) begin
            if (!out_last_reg) begin
              fsm_malformed = 1'b1;
              state_next    = ST_FLUSH;
            end else if (crc_ok) begin
              state_next = ST_PROCESS;
            end else begin
              crc_err_inc = 1'b1;
            end
          end else if (out_last_reg) begin
            fsm_malformed = 1'b1;
          end else begin
            state_next = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (fire) begin
          if (!out_last_reg) begin
            fsm_malformed = 1'b1;
            state_next    = ST_FLUSH;
          end else if (crc_ok) begin
            state_next = ST_PROCESS;
          end else begin
            crc_err_inc = 1'b1;
            state_next  = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (fire && out_last_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (!phy_link_up_i) state_next = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      body_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (body_load) body_reg <= beat_body;
    end
  end

  // ---------------- decode ----------------
  logic [7:0]  b0, b1, b2, b3;
  logic [11:0] dec_seq;
  logic [7:0]  dec_hdr;
  logic [11:0] dec_data;
  logic [2:0]  dec_vc;
  logic [1:0]  fc_cls;
  logic        do_dec, is_ack, is_nak, is_pm, is_vendor;
  logic        fc_init1, fc_init2, fc_upd, is_fc, vc_ok;
  logic        dec_malformed, seq_fwd;
  logic [11:0] seq_num_reg, seq_diff;
  logic        seq_vld_reg, acknack_reg, have_seq_reg;
  logic        unused_bits;

  assign {b3, b2, b1, b0} = body_reg;
  assign dec_seq     = {b2[3:0], b3};
  assign dec_hdr     = {b1[5:0], b2[7:6]};
  assign dec_data    = {b2[3:0], b3};
  assign dec_vc      = b0[2:0];
  assign fc_cls      = b0[5:4];
  assign seq_diff    = dec_seq - seq_num_reg;
  assign unused_bits = ^{s_axis_tkeep, s_axis_tuser[USER_WIDTH-1:1], b1[7:6], b2[5:4]};

  always_comb begin
    do_dec    = (state_reg == ST_PROCESS) && phy_link_up_i;
    is_ack    = (b0 == 8'h00);
    is_nak    = (b0 == 8'h10);
    is_pm     = (b0 >= 8'h20) && (b0 <= 8'h24);
    is_vendor = (b0 == 8'h30);
    fc_init1  = (b0[7:4] == 4'h4) || (b0[7:4] == 4'h5) || (b0[7:4] == 4'h6);
    fc_init2  = (b0[7:4] == 4'hC) || (b0[7:4] == 4'hD) || (b0[7:4] == 4'hE);
    fc_upd    = (b0[7:4] == 4'h8) || (b0[7:4] == 4'h9) || (b0[7:4] == 4'hA);
    is_fc     = fc_init1 || fc_init2 || fc_upd;
    vc_ok     = ({29'd0, dec_vc} < NUM_VC);
    dec_malformed = do_dec && ((is_fc && !vc_ok) ||
                               !(is_ack || is_nak || is_fc || is_pm || is_vendor));
    // An Ack/Nak more than half the sequence space behind the last one is stale
    seq_fwd = do_dec && (is_ack || is_nak) && !(have_seq_reg && seq_diff[11]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_err_cnt_o   <= '0;
      malformed_cnt_o <= '0;
      seq_num_reg     <= '0;
      seq_vld_reg     <= 1'b0;
      acknack_reg     <= 1'b0;
      have_seq_reg    <= 1'b0;
    end else begin
      if (crc_err_inc && (crc_err_cnt_o != '1))
        crc_err_cnt_o <= crc_err_cnt_o + ERR_CNT_WIDTH'(1);
      if ((fsm_malformed || dec_malformed) && (malformed_cnt_o != '1))
        malformed_cnt_o <= malformed_cnt_o + ERR_CNT_WIDTH'(1);
      seq_vld_reg <= seq_fwd;
      if (seq_fwd) begin
        seq_num_reg  <= dec_seq;
        acknack_reg  <= is_ack;
        have_seq_reg <= 1'b1;
      end
      if (!phy_link_up_i) have_seq_reg <= 1'b0;
    end
  end

  assign seq_num_o         = seq_num_reg;
  assign seq_num_vld_o     = seq_vld_reg;
  assign seq_num_acknack_o = acknack_reg;

  // ---------------- per-VC credit state ----------------
  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    logic [7:0]  ph_reg, nph_reg, cplh_reg;
    logic [11:0] pd_reg, npd_reg, cpld_reg;
    logic [2:0]  fc1_got_reg, fc2_got_reg;
    logic [2:0]  cls_bit;
    logic        upd_reg, hit, upd_ok, wr;

    assign hit     = do_dec && is_fc && vc_ok && (dec_vc == 3'(gi));
    assign cls_bit = 3'b001 << fc_cls;
    assign upd_ok  = fc_upd && (&fc2_got_reg);
    assign wr      = hit && (fc_init1 || fc_init2 || upd_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        {ph_reg, nph_reg, cplh_reg} <= '0;
        {pd_reg, npd_reg, cpld_reg} <= '0;
        fc1_got_reg <= '0;
        fc2_got_reg <= '0;
        upd_reg     <= 1'b0;
      end else if (!phy_link_up_i) begin
        {ph_reg, nph_reg, cplh_reg} <= '0;
        {pd_reg, npd_reg, cpld_reg} <= '0;
        fc1_got_reg <= '0;
        fc2_got_reg <= '0;
        upd_reg     <= 1'b0;
      end else begin
        upd_reg <= 1'b0;
        if (hit && fc_init1) fc1_got_reg <= fc1_got_reg | cls_bit;
        if (hit && fc_init2) begin
          fc2_got_reg <= fc2_got_reg | cls_bit;
          if (!(&fc2_got_reg) && (&(fc2_got_reg | cls_bit))) upd_reg <= 1'b1;
        end
        if (hit && upd_ok) upd_reg <= 1'b1;
        if (wr) begin
          case (fc_cls)
            2'd0:    begin ph_reg   <= dec_hdr; pd_reg   <= dec_data; end
            2'd1:    begin nph_reg  <= dec_hdr; npd_reg  <= dec_data; end
            default: begin cplh_reg <= dec_hdr; cpld_reg <= dec_data; end
          endcase
        end
      end
    end

    assign tx_fc_ph_o[8*gi +: 8]     = ph_reg;
    assign tx_fc_nph_o[8*gi +: 8]    = nph_reg;
    assign tx_fc_cplh_o[8*gi +: 8]   = cplh_reg;
    assign tx_fc_pd_o[12*gi +: 12]   = pd_reg;
    assign tx_fc_npd_o[12*gi +: 12]  = npd_reg;
    assign tx_fc_cpld_o[12*gi +: 12] = cpld_reg;
    assign update_fc_o[gi]           = upd_reg;
    assign fc1_values_stored_o[gi]   = &fc1_got_reg;
    assign fc2_values_stored_o[gi]   = &fc2_got_reg;
  end

endmodule

// File: tb/tb_dllp_rx_handler_mvc.sv
// Directed bench for dllp_rx_handler_mvc at 32-bit datapath with two VCs.
module tb_dllp_rx_handler_mvc;
  localparam int DW = 32;
  localparam int NV = 2;

  logic clk = 1'b0;
  logic rst_ni, link_up;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tkeep;
  logic tvalid, tlast, tready;
  logic [3:0] tuser;
  logic [11:0] seq_num;
  logic seq_vld, seq_an;
  logic [8*NV-1:0] ph, nph, cplh;
  logic [12*NV-1:0] pd, npd, cpld;
  logic [NV-1:0] upd, fc1s, fc2s;
  logic [15:0] crc_cnt, mal_cnt;

  int total = 0;
  int bad = 0;
  int vld_cnt = 0;
  int upd0_cnt = 0;
  int upd1_cnt = 0;
  logic [11:0] mon_seq = '0;
  logic mon_an = 1'b0;

  always #5 clk = ~clk;

  dllp_rx_handler_mvc #(.DATA_WIDTH(DW), .NUM_VC(NV)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .phy_link_up_i(link_up),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser), .s_axis_tready(tready),
    .seq_num_o(seq_num), .seq_num_vld_o(seq_vld), .seq_num_acknack_o(seq_an),
    .tx_fc_ph_o(ph), .tx_fc_nph_o(nph), .tx_fc_cplh_o(cplh),
    .tx_fc_pd_o(pd), .tx_fc_npd_o(npd), .tx_fc_cpld_o(cpld),
    .update_fc_o(upd), .fc1_values_stored_o(fc1s), .fc2_values_stored_o(fc2s),
    .crc_err_cnt_o(crc_cnt), .malformed_cnt_o(mal_cnt)
  );

  // pulse monitor
  always @(negedge clk) begin
    if (rst_ni) begin
      if (seq_vld) begin
        vld_cnt++;
        mon_seq = seq_num;
        mon_an  = seq_an;
      end
      if (upd[0]) upd0_cnt++;
      if (upd[1]) upd1_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] crc_ref(input logic [31:0] body);
    logic [15:0] r;
    logic [7:0] byt;
    logic fb;
    r = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      byt = body[8*k +: 8];
      for (int j = 0; j < 8; j++) begin
        fb = r[15] ^ byt[j];
        r = r << 1;
        if (fb) r = r ^ 16'h100B;
      end
    end
    return ~r;
  endfunction

  function automatic logic [31:0] fc_body(input logic [7:0] typ, input logic [7:0] hdr, input logic [11:0] dat);
    return {dat[7:0], hdr[1:0], 2'b00, dat[11:8], 2'b00, hdr[7:2], typ};
  endfunction

  function automatic logic [31:0] seq_body(input logic [7:0] typ, input logic [11:0] seq);
    return {seq[7:0], 4'h0, seq[11:8], 8'h00, typ};
  endfunction

  task automatic send_beat(input logic [31:0] data, input logic last, input logic user);
    int n;
    @(negedge clk);
    tdata = data; tlast = last; tuser = {3'b000, user}; tvalid = 1'b1;
    n = 0;
    while (!tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("tready_wait", {31'd0, tready}, 32'd1);
    @(posedge clk);
    #1 tvalid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_dllp(input logic [31:0] body, input logic [15:0] crc_flip);
    send_beat(body, 1'b0, 1'b1);
    send_beat({16'h0000, crc_ref(body) ^ crc_flip}, 1'b1, 1'b1);
    wait_cycles(5);
    $display("sent dllp body=0x%08h crc_flip=0x%0h", body, crc_flip);
  endtask

  initial begin
    rst_ni = 1'b0; link_up = 1'b0;
    tdata = '0; tkeep = '1; tvalid = 1'b0; tlast = 1'b0; tuser = '0;
    wait_cycles(3);
    check("rst_tready", {31'd0, tready}, 32'd0);
    check("rst_fc2", {30'd0, fc2s}, 32'd0);
    check("rst_ph", {16'd0, ph}, 32'd0);
    check("rst_crc_cnt", {16'd0, crc_cnt}, 32'd0);
    check("rst_mal_cnt", {16'd0, mal_cnt}, 32'd0);
    check("rst_seq_vld", {31'd0, seq_vld}, 32'd0);
    rst_ni = 1'b1; link_up = 1'b1;
    wait_cycles(3);
    check("linkup_tready", {31'd0, tready}, 32'd1);

    // InitFC1 then InitFC2 on VC1
    send_dllp(fc_body(8'h41, 8'h20, 12'h100), 16'h0);
    send_dllp(fc_body(8'h51, 8'h11, 12'h022), 16'h0);
    send_dllp(fc_body(8'h61, 8'h33, 12'h044), 16'h0);
    check("fc1_vc1", {30'd0, fc1s}, 32'h2);
    check("fc2_after_fc1", {30'd0, fc2s}, 32'h0);
    send_dllp(fc_body(8'hC1, 8'h20, 12'h100), 16'h0);
    send_dllp(fc_body(8'hD1, 8'h11, 12'h022), 16'h0);
    check("fc2_partial", {30'd0, fc2s}, 32'h0);
    check("upd1_partial", upd1_cnt, 32'd0);
    send_dllp(fc_body(8'hE1, 8'h33, 12'h044), 16'h0);
    check("fc2_vc1", {30'd0, fc2s}, 32'h2);
    check("ph_vc1", {24'd0, ph[15:8]}, 32'h20);
    check("pd_vc1", {20'd0, pd[23:12]}, 32'h100);
    check("nph_vc1", {24'd0, nph[15:8]}, 32'h11);
    check("cpld_vc1", {20'd0, cpld[23:12]}, 32'h044);
    check("upd1_once", upd1_cnt, 32'd1);
    check("upd0_none", upd0_cnt, 32'd0);

    // UpdateFC on VC0 before and after its InitFC2 completes
    send_dllp(fc_body(8'h80, 8'h05, 12'h0AB), 16'h0);
    check("updfc_early_ph", {24'd0, ph[7:0]}, 32'h0);
    check("updfc_early_pulse", upd0_cnt, 32'd0);
    send_dllp(fc_body(8'hC0, 8'h01, 12'h001), 16'h0);
    send_dllp(fc_body(8'hD0, 8'h01, 12'h001), 16'h0);
    send_dllp(fc_body(8'hE0, 8'h01, 12'h001), 16'h0);
    check("fc2_both", {30'd0, fc2s}, 32'h3);
    check("upd0_complete", upd0_cnt, 32'd1);
    check("ph_vc0_init", {24'd0, ph[7:0]}, 32'h01);
    send_dllp(fc_body(8'h80, 8'h05, 12'h0AB), 16'h0);
    check("updfc_ph", {24'd0, ph[7:0]}, 32'h05);
    check("updfc_pd", {20'd0, pd[11:0]}, 32'h0AB);
    check("updfc_pulse", upd0_cnt, 32'd2);
    check("updfc_vc1_kept", {24'd0, ph[15:8]}, 32'h20);

    // Ack/Nak and stale detection
    send_dllp(seq_body(8'h00, 12'd5), 16'h0);
    check("ack5_cnt", vld_cnt, 32'd1);
    check("ack5_seq", {20'd0, mon_seq}, 32'd5);
    check("ack5_an", {31'd0, mon_an}, 32'd1);
    send_dllp(seq_body(8'h10, 12'd7), 16'h0);
    check("nak7_cnt", vld_cnt, 32'd2);
    check("nak7_seq", {20'd0, mon_seq}, 32'd7);
    check("nak7_an", {31'd0, mon_an}, 32'd0);
    send_dllp(seq_body(8'h00, 12'd4094), 16'h0);
    check("ack4094_stale", vld_cnt, 32'd2);
    check("ack4094_seq_kept", {20'd0, seq_num}, 32'd7);
    send_dllp(seq_body(8'h00, 12'd2000), 16'h0);
    send_dllp(seq_body(8'h00, 12'd4000), 16'h0);
    send_dllp(seq_body(8'h00, 12'd4090), 16'h0);
    check("walk_cnt", vld_cnt, 32'd5);
    check("walk_seq", {20'd0, seq_num}, 32'd4090);
    send_dllp(seq_body(8'h00, 12'd3), 16'h0);
    check("wrap_cnt", vld_cnt, 32'd6);
    check("wrap_seq", {20'd0, mon_seq}, 32'd3);

    // Bad CRC then good DLLP
    send_dllp(seq_body(8'h00, 12'd9), 16'h0001);
    check("badcrc_no_pulse", vld_cnt, 32'd6);
    check("badcrc_cnt", {16'd0, crc_cnt}, 32'd1);
    send_dllp(seq_body(8'h00, 12'd9), 16'h0);
    check("goodcrc_cnt", vld_cnt, 32'd7);
    check("goodcrc_seq", {20'd0, mon_seq}, 32'd9);

    // Malformed cases
    send_dllp(fc_body(8'h45, 8'h10, 12'h010), 16'h0);
    check("bad_vc_mal", {16'd0, mal_cnt}, 32'd1);
    check("bad_vc_fc1", {30'd0, fc1s}, 32'h2);
    send_beat(seq_body(8'h00, 12'd10), 1'b1, 1'b1);
    wait_cycles(5);
    check("single_beat_mal", {16'd0, mal_cnt}, 32'd2);
    send_dllp(32'h0000_0020, 16'h0);
    send_dllp(32'h0000_0030, 16'h0);
    check("pm_vendor_mal", {16'd0, mal_cnt}, 32'd2);
    send_dllp(32'h0000_0070, 16'h0);
    check("unknown_mal", {16'd0, mal_cnt}, 32'd3);
    send_beat(seq_body(8'h00, 12'd10), 1'b0, 1'b1);
    send_beat({16'h0000, crc_ref(seq_body(8'h00, 12'd10))}, 1'b0, 1'b1);
    send_beat(32'h0000_DEAD, 1'b1, 1'b1);
    wait_cycles(5);
    check("overlong_mal", {16'd0, mal_cnt}, 32'd4);
    check("overlong_no_pulse", vld_cnt, 32'd7);
    send_beat(32'h0000_0000, 1'b1, 1'b0);
    wait_cycles(3);
    send_dllp(seq_body(8'h00, 12'd11), 16'h0);
    check("after_nondllp_cnt", vld_cnt, 32'd8);
    check("after_nondllp_mal", {16'd0, mal_cnt}, 32'd4);

    // Link drop between beat 1 and beat 2
    send_beat(seq_body(8'h00, 12'd20), 1'b0, 1'b1);
    link_up = 1'b0;
    wait_cycles(3);
    check("linkdown_tready", {31'd0, tready}, 32'd0);
    check("linkdown_fc1", {30'd0, fc1s}, 32'h0);
    check("linkdown_fc2", {30'd0, fc2s}, 32'h0);
    check("linkdown_ph", {16'd0, ph}, 32'h0);
    check("linkdown_pd", pd, 32'h0);
    check("linkdown_crc_cnt", {16'd0, crc_cnt}, 32'd1);
    check("linkdown_mal_cnt", {16'd0, mal_cnt}, 32'd4);
    link_up = 1'b1;
    wait_cycles(3);
    check("linkdown_dropped", vld_cnt, 32'd8);
    send_dllp(seq_body(8'h00, 12'd5), 16'h0);
    check("relink_first_ack", vld_cnt, 32'd9);
    check("relink_seq", {20'd0, mon_seq}, 32'd5);

    // Reset mid-packet
    send_dllp(fc_body(8'hC1, 8'h07, 12'h070), 16'h0);
    send_dllp(fc_body(8'hD1, 8'h07, 12'h070), 16'h0);
    send_dllp(fc_body(8'hE1, 8'h07, 12'h070), 16'h0);
    check("pre_rst_fc2", {30'd0, fc2s}, 32'h2);
    check("pre_rst_upd1", upd1_cnt, 32'd2);
    send_beat(seq_body(8'h00, 12'd30), 1'b0, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_fc2", {30'd0, fc2s}, 32'h0);
    check("midrst_ph", {16'd0, ph}, 32'h0);
    check("midrst_seq", {20'd0, seq_num}, 32'd0);
    check("midrst_crc_cnt", {16'd0, crc_cnt}, 32'd0);
    check("midrst_mal_cnt", {16'd0, mal_cnt}, 32'd0);
    check("midrst_tready", {31'd0, tready}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
